icache_direct_mapped: RTL
=========================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped, read-only instruction cache between the IF-side sram->sram_like adapter (upstream) and the
//  instruction port of the AXI bridge (downstream). Both sides use sram_like handshakes (req/addr_ok/data_ok).
//  Hits return in 1 cycle; misses refill a whole line word-by-word over the memory sram_like port.
// PARAMETERS
//  INDEX_WIDTH   7   line index bits (128 lines)
//  OFFSET_WIDTH  4   byte offset bits (16B line = 4 words); WORDS = 2**(OFFSET_WIDTH-2), TAG = 32-INDEX-OFFSET
// PORTS
//  clk_i             in   1   clock, all state on posedge
//  rst_i             in   1   synchronous, active-high reset
//  cache_inst_req_i  in   1   upstream request
//  cache_inst_wr_i   in   1   ignored (read-only cache)
//  cache_inst_size_i in   2   ignored (always word)
//  cache_inst_addr_i in  32   byte address, word aligned
//  cache_inst_wdata_i in 32   ignored
//  cache_inst_addr_ok_o out 1 request accepted this cycle
//  cache_inst_data_ok_o out 1 cache_inst_rdata_o valid this cycle
//  cache_inst_rdata_o out 32  instruction word
//  mem_inst_req_o    out  1   memory-side request
//  mem_inst_wr_o     out  1   constant 0
//  mem_inst_size_o   out  2   constant 2'b10
//  mem_inst_addr_o   out 32   word address being fetched
//  mem_inst_wdata_o  out 32   constant 0
//  mem_inst_rdata_i  in  32   memory read data
//  mem_inst_addr_ok_i in  1   memory accepted address
//  mem_inst_data_ok_i in  1   memory data valid
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits 0, refill counter 0; every output 0 except constants (size=2'b10).
//  States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, UNC_REQ, UNC_WAIT, RESP.
//  IDLE: addr_ok_o = req_i (combinational). On accept, latch addr -> LOOKUP (or UNC_REQ if uncached, see below).
//  LOOKUP: compare tag[index] with latched tag and valid. Hit: data_ok_o=1, rdata=line word; addr_ok_o=req_i
//   (back-to-back accept, stay LOOKUP with new addr if req_i, else IDLE). Miss: data_ok_o=0, addr_ok_o=0 -> MISS_REQ.
//  MISS_REQ: mem_req_o=1, mem_addr_o={tag,index,cnt,2'b00}, words fetched in order 0..WORDS-1 from line base.
//   addr_ok_i -> MISS_WAIT; addr_ok_i & data_ok_i same cycle: capture word, advance as in MISS_WAIT.
//  MISS_WAIT: mem_req_o=0; data_ok_i -> write word cnt into line; cnt==WORDS-1: set valid+tag, cnt<=0 -> RESP;
//   else cnt++ -> MISS_REQ. Exactly one outstanding memory read at any time.
//  RESP: data_ok_o=1, rdata = requested word (from refill/unc buffer), addr_ok_o=0 -> IDLE.
//  Upstream addr_ok_o is never 1 outside IDLE/LOOKUP-hit; data_ok_o exactly once per accepted request, in order.
//  Upstream flush is not seen here: every accepted request completes; discarding is upstream's job.
//  Reset mid-refill: line not validated, state IDLE next cycle; memory side must tolerate abandoned transaction.
//  Data_ok_i while in any state other than MISS_WAIT/UNC_WAIT/MISS_REQ is ignored.
// CONFIGURATION
//  ICACHE_KSEG1_BYPASS_EN defined: addr[31:29]==3'b101 is uncached: IDLE/LOOKUP-accept -> UNC_REQ (single read
//   of exact addr, req until addr_ok_i) -> UNC_WAIT (until data_ok_i, capture) -> RESP; cache arrays untouched.
//  Not defined: all addresses cached; UNC_* states unreachable and omitted.
// STRUCTURE
//  icache_pkg: state enum icache_state_e, INDEX/OFFSET/TAG width localparams, line/tag struct typedefs,
//   KSEG1 constant 3'b101.
//  Sub-module icache_line_ram: tag+valid+data flop arrays, 1 read port (combinational by latched index),
//   1 word write port, valid clear on rst_i.
// TESTING
//  Cold miss 0x0000_0040 after reset: 4 mem reads 0x40,0x44,0x48,0x4C, then data_ok with word @0x40; no early data_ok.
//  Then req 0x44,0x48,0x4C back-to-back: addr_ok every cycle, data_ok each following cycle, zero mem_req.
//  Conflict: read 0x0000_0840 (same index, new tag) -> refill, then 0x40 misses again.
//  mem addr_ok_i and data_ok_i asserted same cycle throughout refill -> 4 reads in 4 cycles, correct data.
//  rst_i during 3rd refill word -> outputs 0 next cycle; re-read same addr misses and refills fully.
//  With ICACHE_KSEG1_BYPASS_EN: 0xBFC0_0000 read twice -> two single mem reads at 0xBFC0_0000, no line fill;
//   without macro -> one 4-word refill then hit.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Optional feature macro: ICACHE_KSEG1_BYPASS_EN (adds the uncached KSEG1 path states).
package icache_pkg;

  localparam int unsigned INDEX_WIDTH    = 7;
  localparam int unsigned OFFSET_WIDTH   = 4;
  localparam int unsigned WORD_SEL_WIDTH = OFFSET_WIDTH - 2;
  localparam int unsigned WORDS          = 2 ** WORD_SEL_WIDTH;
  localparam int unsigned LINES          = 2 ** INDEX_WIDTH;
  localparam int unsigned TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH;

  // Top three address bits selecting the uncached KSEG1 segment
  localparam logic [2:0] KSEG1 = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait,
    StResp
`ifdef ICACHE_KSEG1_BYPASS_EN
    ,
    StUncReq,
    StUncWait
`endif
  } icache_state_e;

  typedef logic [WORDS-1:0][31:0] line_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]      tag;
    logic [INDEX_WIDTH-1:0]    index;
    logic [WORD_SEL_WIDTH-1:0] word;
    logic [1:0]                byte_off;
  } icache_addr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } tag_entry_t;

  function automatic logic is_kseg1(input logic [31:0] addr);
    return addr[31:29] == KSEG1;
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Tag, valid and data storage for the instruction cache: one combinational read port,
// one word-wide write port, tag/valid written when a refill completes.
module icache_line_ram
  import icache_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [INDEX_WIDTH-1:0]    i_rd_index,
  output tag_entry_t                o_rd_tag,
  output line_t                     o_rd_line,
  input  logic                      i_wr_en,
  input  logic [INDEX_WIDTH-1:0]    i_wr_index,
  input  logic [WORD_SEL_WIDTH-1:0] i_wr_word,
  input  logic [31:0]               i_wr_data,
  input  logic                      i_tag_we,
  input  logic [TAG_WIDTH-1:0]      i_tag
);

  logic [LINES-1:0]     r_valid;
  logic [TAG_WIDTH-1:0] r_tag  [LINES];
  line_t                r_data [LINES];

  // Valid bits: cleared on reset, set when the final word of a line lands
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; a clear valid bit masks their contents
  always_ff @(posedge clk_i) begin
    if (i_tag_we) begin
      r_tag[i_wr_index] <= i_tag;
    end
    if (i_wr_en) begin
      r_data[i_wr_index][i_wr_word] <= i_wr_data;
    end
  end

  assign o_rd_tag.valid = r_valid[i_rd_index];
  assign o_rd_tag.tag   = r_tag[i_rd_index];
  assign o_rd_line      = r_data[i_rd_index];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with sram_like ports on both sides.
// Hits answer the cycle after accept; misses refill the whole line word by word from the
// line base, with exactly one memory read outstanding.
// Optional feature macro: ICACHE_KSEG1_BYPASS_EN makes addr[31:29]==3'b101 uncached.
module icache_direct_mapped
  import icache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cache_inst_req_i,
  input  logic        cache_inst_wr_i,
  input  logic [1:0]  cache_inst_size_i,
  input  logic [31:0] cache_inst_addr_i,
  input  logic [31:0] cache_inst_wdata_i,
  output logic        cache_inst_addr_ok_o,
  output logic        cache_inst_data_ok_o,
  output logic [31:0] cache_inst_rdata_o,
  output logic        mem_inst_req_o,
  output logic        mem_inst_wr_o,
  output logic [1:0]  mem_inst_size_o,
  output logic [31:0] mem_inst_addr_o,
  output logic [31:0] mem_inst_wdata_o,
  input  logic [31:0] mem_inst_rdata_i,
  input  logic        mem_inst_addr_ok_i,
  input  logic        mem_inst_data_ok_i
);

  icache_state_e             r_state;
  icache_addr_t              r_addr;
  logic [WORD_SEL_WIDTH-1:0] r_cnt;
  logic [31:0]               r_resp_data;

  tag_entry_t    w_rd_tag;
  line_t         w_rd_line;
  icache_addr_t  w_req_addr;
  icache_state_e w_accept_state;
  logic          w_hit;
  logic          w_lookup_hit;
  logic          w_accept;
  logic          w_word_done;
  logic          w_refill_last;
  logic          w_unused;

  assign w_req_addr    = icache_addr_t'(cache_inst_addr_i);
  assign w_hit         = w_rd_tag.valid && (w_rd_tag.tag == r_addr.tag);
  assign w_lookup_hit  = (r_state == StLookup) && w_hit;
  // New requests are taken only when idle or while a hit is being answered
  assign w_accept      = cache_inst_req_i && ((r_state == StIdle) || w_lookup_hit);
  // A refill word arrives either with its address handshake or later in the wait state
  assign w_word_done   = ((r_state == StMissReq) && mem_inst_addr_ok_i && mem_inst_data_ok_i) ||
                         ((r_state == StMissWait) && mem_inst_data_ok_i);
  assign w_refill_last = &r_cnt;

`ifdef ICACHE_KSEG1_BYPASS_EN
  assign w_accept_state = is_kseg1(cache_inst_addr_i) ? StUncReq : StLookup;
`else
  assign w_accept_state = StLookup;
`endif

  // Write-side and sub-word inputs have no meaning for a read-only word cache
  assign w_unused = ^{cache_inst_wr_i, cache_inst_size_i, cache_inst_wdata_i, r_addr.byte_off};

  icache_line_ram u_line_ram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_rd_index (r_addr.index),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_wr_en    (w_word_done),
    .i_wr_index (r_addr.index),
    .i_wr_word  (r_cnt),
    .i_wr_data  (mem_inst_rdata_i),
    .i_tag_we   (w_word_done && w_refill_last),
    .i_tag      (r_addr.tag)
  );

  // Control FSM: request latch, refill sequencing and response buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_resp_data <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cache_inst_req_i) begin
            r_addr  <= w_req_addr;
            r_state <= w_accept_state;
          end
        end
        StLookup: begin
          if (w_hit) begin
            if (cache_inst_req_i) begin
              r_addr  <= w_req_addr;
              r_state <= w_accept_state;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_state <= StMissReq;
          end
        end
        StMissReq: begin
          if (mem_inst_addr_ok_i && !mem_inst_data_ok_i) begin
            r_state <= StMissWait;
          end
        end
        StMissWait: begin
          r_state <= StMissWait;
        end
`ifdef ICACHE_KSEG1_BYPASS_EN
        StUncReq: begin
          if (mem_inst_addr_ok_i) begin
            if (mem_inst_data_ok_i) begin
              r_resp_data <= mem_inst_rdata_i;
              r_state     <= StResp;
            end else begin
              r_state <= StUncWait;
            end
          end
        end
        StUncWait: begin
          if (mem_inst_data_ok_i) begin
            r_resp_data <= mem_inst_rdata_i;
            r_state     <= StResp;
          end
        end
`endif
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase

      // Refill step overrides the per-state defaults above
      if (w_word_done) begin
        if (r_cnt == r_addr.word) begin
          r_resp_data <= mem_inst_rdata_i;
        end
        if (w_refill_last) begin
          r_cnt   <= '0;
          r_state <= StResp;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= StMissReq;
        end
      end
    end
  end

  // Output decode from state; hit data comes straight from the array
  always_comb begin
    cache_inst_addr_ok_o = w_accept;
    cache_inst_data_ok_o = w_lookup_hit || (r_state == StResp);
    cache_inst_rdata_o   = '0;
    mem_inst_req_o       = 1'b0;
    mem_inst_addr_o      = '0;
    mem_inst_wr_o        = 1'b0;
    mem_inst_size_o      = 2'b10;
    mem_inst_wdata_o     = '0;

    if (w_lookup_hit) begin
      cache_inst_rdata_o = w_rd_line[r_addr.word];
    end else if (r_state == StResp) begin
      cache_inst_rdata_o = r_resp_data;
    end

    if (r_state == StMissReq) begin
      mem_inst_req_o  = 1'b1;
      mem_inst_addr_o = {r_addr.tag, r_addr.index, r_cnt, 2'b00};
    end
`ifdef ICACHE_KSEG1_BYPASS_EN
    if (r_state == StUncReq) begin
      mem_inst_req_o  = 1'b1;
      mem_inst_addr_o = r_addr;
    end
`endif
  end

endmodule
